pipe_mult_acc: RTL and testbench



---
 rtl/pipe_mult_acc_if.sv | 25 ++
 rtl/pipe_mult_acc.sv | 89 ++++++++
 tb/tb_pipe_mult_acc.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_mult_acc_if.sv
// Handshake and operand bundle for the pipelined multiply-accumulate unit.
// The master issues requests; the slave (the multiplier) returns status and result.
interface pipe_mult_acc_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               sign_en;
    logic               acc_en;
    logic               busy;
    logic               done_mult;
    logic [2*WIDTH-1:0] result_mult;
    logic               ovf;

    modport master (
        output start, A, B, sign_en, acc_en,
        input  busy, done_mult, result_mult, ovf
    );

    modport slave (
        input  start, A, B, sign_en, acc_en,
        output busy, done_mult, result_mult, ovf
    );
endinterface

// File: rtl/pipe_mult_acc.sv
// WIDTH x WIDTH signed/unsigned multiplier with optional accumulate.
// Operands are captured at acceptance; the result lands exactly STAGES edges later.
module pipe_mult_acc #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             reset,
    pipe_mult_acc_if.slave   mul_if
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(STAGES + 1);
    localparam logic [CW:0] CNT_TWO = 2;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sign;
    logic             r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic [PW-1:0]    r_result;

    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic [PW-1:0]    w_prod;
    logic [PW:0]      w_sum_c;
    logic             w_ovf_u;
    logic             w_ovf_s;
    logic             w_accept;
    logic             w_finish;

    // Product is taken modulo 2^PW, which is exact for sign-extended operands.
    assign w_a_ext  = r_sign ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_b_ext  = r_sign ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod   = w_a_ext * w_b_ext;
    assign w_sum_c  = {1'b0, r_result} + {1'b0, w_prod};
    assign w_ovf_u  = w_sum_c[PW];
    assign w_ovf_s  = (r_result[PW-1] == w_prod[PW-1]) && (w_sum_c[PW-1] != r_result[PW-1]);

    assign w_accept = mul_if.start && !r_busy;
    assign w_finish = (r_cnt == CW'(1));

    // r_cnt holds the edges remaining until the result edge; with STAGES=1 the
    // finishing edge may also accept the next operation, so accept is applied last.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sign   <= 1'b0;
            r_acc    <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            if (r_cnt != '0) begin
                r_cnt  <= r_cnt - CW'(1);
                r_busy <= ({1'b0, r_cnt} >= CNT_TWO);
                if (w_finish) begin
                    r_done <= 1'b1;
                    if (r_acc) begin
                        r_result <= w_sum_c[PW-1:0];
                        r_ovf    <= r_sign ? w_ovf_s : w_ovf_u;
                    end else begin
                        r_result <= w_prod;
                    end
                end
            end
            if (w_accept) begin
                r_a    <= mul_if.A;
                r_b    <= mul_if.B;
                r_sign <= mul_if.sign_en;
                r_acc  <= mul_if.acc_en;
                r_cnt  <= CW'(STAGES);
                r_busy <= (STAGES > 1);
            end
        end
    end

    assign mul_if.busy        = r_busy;
    assign mul_if.done_mult   = r_done;
    assign mul_if.result_mult = r_result;
    assign mul_if.ovf         = r_ovf;
endmodule

// File: tb/tb_pipe_mult_acc.sv
// Directed bench for pipe_mult_acc: default 8x8/3-stage unit plus 16-bit
// variants with one and eight stages, all driven and sampled 1 time unit after clk rises.
module tb_pipe_mult_acc;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_mult_acc_if #(.WIDTH(8))  if0 ();
    pipe_mult_acc_if #(.WIDTH(16)) if1 ();
    pipe_mult_acc_if #(.WIDTH(16)) if2 ();

    pipe_mult_acc #(.WIDTH(8),  .STAGES(3)) u0 (.clk(clk), .reset(reset), .mul_if(if0));
    pipe_mult_acc #(.WIDTH(16), .STAGES(1)) u1 (.clk(clk), .reset(reset), .mul_if(if1));
    pipe_mult_acc #(.WIDTH(16), .STAGES(8)) u2 (.clk(clk), .reset(reset), .mul_if(if2));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation on the 8-bit unit; operands are scrambled right after
    // acceptance to confirm they were captured. lat counts edges after E0.
    task automatic run0(input logic [7:0] a, input logic [7:0] b, input logic s, input logic acc,
                        output logic [15:0] res, output logic o, output int lat);
        if0.A = a; if0.B = b; if0.sign_en = s; if0.acc_en = acc; if0.start = 1'b1;
        tick();
        if0.start = 1'b0; if0.A = ~a; if0.B = 8'h5A; if0.sign_en = ~s; if0.acc_en = ~acc;
        lat = 0;
        while (!if0.done_mult && lat < 20) begin
            tick();
            lat++;
        end
        res = if0.result_mult;
        o   = if0.ovf;
        $display("op a=%h b=%h s=%0d acc=%0d -> result=%h ovf=%0d lat=%0d", a, b, s, acc, res, o, lat);
    endtask

    logic [15:0] res;
    logic        o;
    int          lat;
    int          n_done;
    int          k;
    logic        busy_bad;

    initial begin
        reset = 1'b1;
        if0.start = 0; if0.A = 0; if0.B = 0; if0.sign_en = 0; if0.acc_en = 0;
        if1.start = 0; if1.A = 0; if1.B = 0; if1.sign_en = 0; if1.acc_en = 0;
        if2.start = 0; if2.A = 0; if2.B = 0; if2.sign_en = 0; if2.acc_en = 0;
        tick(); tick();
        check("rst_busy",   64'(if0.busy), 64'd0);
        check("rst_done",   64'(if0.done_mult), 64'd0);
        check("rst_ovf",    64'(if0.ovf), 64'd0);
        check("rst_result", 64'(if0.result_mult), 64'd0);
        reset = 1'b0;

        // Cycle-exact latency and busy profile for 3*5.
        if0.A = 8'd3; if0.B = 8'd5; if0.start = 1'b1;
        tick();
        if0.start = 1'b0; if0.A = 8'd9;
        check("t1_busy_e0", 64'(if0.busy), 64'd1);
        check("t1_done_e0", 64'(if0.done_mult), 64'd0);
        tick();
        check("t1_busy_e1", 64'(if0.busy), 64'd1);
        tick();
        check("t1_busy_e2", 64'(if0.busy), 64'd1);
        check("t1_done_e2", 64'(if0.done_mult), 64'd0);
        tick();
        check("t1_busy_e3", 64'(if0.busy), 64'd0);
        check("t1_done_e3", 64'(if0.done_mult), 64'd1);
        check("t1_result",  64'(if0.result_mult), 64'd15);
        check("t1_ovf",     64'(if0.ovf), 64'd0);
        $display("op a=03 b=05 -> result=%h", if0.result_mult);
        tick();
        check("t1_done_pulse", 64'(if0.done_mult), 64'd0);
        check("t1_hold",       64'(if0.result_mult), 64'd15);

        // Signed versus unsigned products.
        run0(8'hFF, 8'hFF, 1'b0, 1'b0, res, o, lat);
        check("t2_uns_ff", 64'(res), 64'hFE01);
        check("t2_lat",    64'(lat), 64'd3);
        run0(8'hFF, 8'hFF, 1'b1, 1'b0, res, o, lat);
        check("t2_sgn_m1", 64'(res), 64'h0001);
        run0(8'h80, 8'h7F, 1'b1, 1'b0, res, o, lat);
        check("t2_sgn_80x7f", 64'(res), 64'hC080);

        // Start held high: each done cycle ends at the edge that accepts the next op,
        // so dones arrive after edges 3, 7, 11 counted from the first acceptance.
        run0(8'd0, 8'd0, 1'b0, 1'b0, res, o, lat);
        check("t3_zero", 64'(res), 64'd0);
        tick();
        if0.A = 8'd2; if0.B = 8'd2; if0.sign_en = 1'b0; if0.acc_en = 1'b1; if0.start = 1'b1;
        n_done = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (if0.done_mult) begin
                $display("b2b done edge=%0d result=%h", e, if0.result_mult);
                check("t3_seq",  64'(if0.result_mult), 64'(4 * (n_done + 1)));
                check("t3_edge", 64'(e), 64'(3 + 4 * n_done));
                n_done++;
            end
        end
        if0.start = 1'b0;
        check("t3_count", 64'(n_done), 64'd3);
        tick(); tick(); tick(); tick(); tick();
        check("t3_no_extra", 64'(if0.result_mult), 64'd12);

        // Accumulate overflow, unsigned then signed.
        run0(8'hFF, 8'hFF, 1'b0, 1'b0, res, o, lat);
        run0(8'h02, 8'hFF, 1'b0, 1'b1, res, o, lat);
        check("t4_ffff", 64'(res), 64'hFFFF);
        check("t4_ffff_ovf", 64'(o), 64'd0);
        run0(8'h01, 8'h01, 1'b0, 1'b1, res, o, lat);
        check("t4_uwrap", 64'(res), 64'h0000);
        check("t4_uovf",  64'(o), 64'd1);
        tick();
        check("t4_ovf_pulse", 64'(if0.ovf), 64'd0);
        run0(8'hD9, 8'h97, 1'b0, 1'b0, res, o, lat);
        check("t4_7fff", 64'(res), 64'h7FFF);
        run0(8'h01, 8'h01, 1'b1, 1'b1, res, o, lat);
        check("t4_swrap", 64'(res), 64'h8000);
        check("t4_sovf",  64'(o), 64'd1);

        // Reset one cycle after acceptance; a start coinciding with reset is ignored.
        tick();
        if0.A = 8'd7; if0.B = 8'd7; if0.sign_en = 1'b0; if0.acc_en = 1'b0; if0.start = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; if0.start = 1'b0;
        check("t5_busy",   64'(if0.busy), 64'd0);
        check("t5_result", 64'(if0.result_mult), 64'd0);
        n_done = 0;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (if0.done_mult || if0.busy) n_done++;
        end
        check("t5_no_done", 64'(n_done), 64'd0);
        run0(8'd1, 8'd9, 1'b0, 1'b0, res, o, lat);
        check("t5_result9", 64'(res), 64'd9);
        check("t5_lat",     64'(lat), 64'd3);

        // Single-stage 16-bit unit: busy never rises, done after E0+1.
        if1.A = 16'hFFFF; if1.B = 16'h0002; if1.sign_en = 1'b0; if1.acc_en = 1'b0; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        check("t6_s1_busy", 64'(if1.busy), 64'd0);
        check("t6_s1_done_e0", 64'(if1.done_mult), 64'd0);
        tick();
        check("t6_s1_done_e1", 64'(if1.done_mult), 64'd1);
        check("t6_s1_result",  64'(if1.result_mult), 64'h0001FFFE);
        $display("op16 s1 a=ffff b=0002 -> result=%h", if1.result_mult);

        // Eight-stage unit: busy high up to the done cycle, done after E0+8.
        if2.A = 16'd3; if2.B = 16'd4; if2.sign_en = 1'b0; if2.acc_en = 1'b0; if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        k = 0;
        busy_bad = 1'b0;
        while (!if2.done_mult && k < 30) begin
            if (!if2.busy) busy_bad = 1'b1;
            tick();
            k++;
        end
        check("t6_s8_lat",    64'(k), 64'd8);
        check("t6_s8_busy",   64'(busy_bad), 64'd0);
        check("t6_s8_bdone",  64'(if2.busy), 64'd0);
        check("t6_s8_result", 64'(if2.result_mult), 64'd12);
        $display("op16 s8 a=0003 b=0004 -> result=%h lat=%0d", if2.result_mult, k);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
